// File: rtl/register_file_8x32.sv
// 8 x WIDTH register file: one-hot write port, two registered read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module register_file_8x32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [7:0]       wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ra,
  input  logic [2:0]       rb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  output logic             wack,
  output logic             sel_err
);

  logic [WIDTH-1:0] rf_q [8];
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             wack_q, wack_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_onehot;
  logic             wr_legal;
  logic             wr_bad;
  logic [2:0]       wr_idx;

  assign sel_onehot = (wsel != 8'h00) &&
                      ((wsel & (wsel - 8'd1)) == 8'h00);
  assign wr_legal   = we & sel_onehot;
  assign wr_bad     = we & ~sel_onehot;

  // Encode the one-hot select into a register index.
  always_comb begin
    wr_idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (wsel[k]) wr_idx = 3'(k);
    end
  end

  // Next read data; r0 always reads as zero, bypass never touches it.
  always_comb begin
    qa_d = (ra == 3'd0) ? '0 : rf_q[ra];
    qb_d = (rb == 3'd0) ? '0 : rf_q[rb];
`ifdef REGFILE_BYPASS_EN
    if (wr_legal && wr_idx != 3'd0 && wr_idx == ra) qa_d = wdata;
    if (wr_legal && wr_idx != 3'd0 && wr_idx == rb) qb_d = wdata;
`endif
  end

  // Write acknowledge and sticky illegal-select flag.
  always_comb begin
    wack_d    = wr_legal;
    sel_err_d = sel_err_q | wr_bad;
  end

  // Register array; r0 is never loaded so it stays at its reset zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) rf_q[k] <= '0;
    end else if (wr_legal && wr_idx != 3'd0) begin
      rf_q[wr_idx] <= wdata;
    end
  end

  // Output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qa_q      <= '0;
      qb_q      <= '0;
      wack_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      qa_q      <= qa_d;
      qb_q      <= qb_d;
      wack_q    <= wack_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign qa      = qa_q;
  assign qb      = qb_q;
  assign wack    = wack_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_register_file_8x32.sv
// Randomized self-checking bench for register_file_8x32.
// Reference model: plain array of register values plus a sticky error bit.
module tb_register_file_8x32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [7:0]  wsel;
  logic [31:0] wdata;
  logic [2:0]  ra, rb;
  logic [31:0] qa, qb;
  logic        wack, sel_err;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] m_rf [8];
  bit          m_err;

  register_file_8x32 #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wsel    (wsel),
    .wdata   (wdata),
    .ra      (ra),
    .rb      (rb),
    .qa      (qa),
    .qb      (qb),
    .wack    (wack),
    .sel_err (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] idx,
                                         input bit legal,
                                         input int widx,
                                         input logic [31:0] d);
    if (idx == 3'd0) return 32'h0;
    if (BYP && legal && widx == int'(idx)) return d;
    return m_rf[idx];
  endfunction

  // One clock: drive, predict, clock, compare, update model.
  task automatic step(input bit rn, input bit w,
                      input logic [7:0] s, input logic [31:0] d,
                      input logic [2:0] a, input logic [2:0] b);
    bit legal;
    int widx;
    logic [31:0] e_qa, e_qb;
    bit e_wack, e_err;
    rst_n = rn; we = w; wsel = s; wdata = d; ra = a; rb = b;
    legal = w && ($countones(s) == 1);
    widx = 0;
    for (int k = 0; k < 8; k++) if (s[k]) widx = k;
    if (!rn) begin
      e_qa = 0; e_qb = 0; e_wack = 0; e_err = 0;
    end else begin
      e_qa = m_read(a, legal, widx, d);
      e_qb = m_read(b, legal, widx, d);
      e_wack = legal;
      e_err = m_err || (w && !legal);
    end
    @(posedge clk);
    #1;
    check("qa", qa, e_qa);
    check("qb", qb, e_qb);
    check("wack", {31'h0, wack}, {31'h0, e_wack});
    check("sel_err", {31'h0, sel_err}, {31'h0, e_err});
    if (!rn) begin
      for (int k = 0; k < 8; k++) m_rf[k] = 32'h0;
    end else if (legal && widx != 0) begin
      m_rf[widx] = d;
    end
    m_err = e_err;
  endtask

  initial begin
    logic [7:0] s;
    for (int k = 0; k < 8; k++) m_rf[k] = 32'h0;
    m_err = 0;
    rst_n = 0; we = 0; wsel = 0; wdata = 0; ra = 0; rb = 0;
    #2;

    // reset beats a pending write to r2
    step(0, 1, 8'h04, 32'hDEADBEEF, 3'd2, 3'd2);
    step(0, 1, 8'h04, 32'hDEADBEEF, 3'd2, 3'd2);
    step(1, 0, 8'h00, 32'h0, 3'd2, 3'd2);
    check("rst_r2", qa, 32'h0);
    check("rst_wack", {31'h0, wack}, 32'h0);
    check("rst_err", {31'h0, sel_err}, 32'h0);

    // basic write/read of r5
    step(1, 1, 8'h20, 32'h12345678, 3'd0, 3'd0);
    check("wr5_wack", {31'h0, wack}, 32'h1);
    step(1, 0, 8'h00, 32'h0, 3'd5, 3'd0);
    check("rd5", qa, 32'h12345678);
    check("wr5_wack_1cyc", {31'h0, wack}, 32'h0);

    // r0 discards writes but still acknowledges
    step(1, 1, 8'h01, 32'hFFFFFFFF, 3'd0, 3'd0);
    check("r0_wack", {31'h0, wack}, 32'h1);
    step(1, 0, 8'h00, 32'h0, 3'd0, 3'd0);
    check("r0_rd", qa, 32'h0);

    // illegal select leaves r1/r2 alone and sets a sticky flag
    step(1, 1, 8'h02, 32'h00000111, 3'd0, 3'd0);
    step(1, 1, 8'h04, 32'h00000222, 3'd0, 3'd0);
    step(1, 1, 8'h06, 32'hAAAA5555, 3'd1, 3'd2);
    check("ill_wack", {31'h0, wack}, 32'h0);
    check("ill_err", {31'h0, sel_err}, 32'h1);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00, 32'h0, 3'd1, 3'd2);
    check("ill_r1", qa, 32'h00000111);
    check("ill_r2", qb, 32'h00000222);
    check("ill_sticky", {31'h0, sel_err}, 32'h1);

    // same-cycle read and write of r3
    step(1, 1, 8'h08, 32'h1, 3'd0, 3'd0);
    step(1, 1, 8'h08, 32'h2, 3'd3, 3'd0);
    check("rw_same", qa, BYP ? 32'h2 : 32'h1);
    step(1, 0, 8'h00, 32'h0, 3'd3, 3'd0);
    check("rw_after", qa, 32'h2);

    // dual read ports
    step(1, 1, 8'h40, 32'hA, 3'd0, 3'd0);
    step(1, 1, 8'h80, 32'hB, 3'd0, 3'd0);
    step(1, 0, 8'h00, 32'h0, 3'd6, 3'd7);
    check("dual_a", qa, 32'hA);
    check("dual_b", qb, 32'hB);
    step(1, 0, 8'h00, 32'h0, 3'd7, 3'd7);
    check("same_a", qa, 32'hB);
    check("same_b", qb, 32'hB);

    // randomized traffic with occasional resets and bad selects
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: s = 8'h00;
        1: s = 8'($urandom);
        default: s = 8'h01 << $urandom_range(0, 7);
      endcase
      step(($urandom_range(0, 39) != 0), 1'($urandom),
           s, $urandom, 3'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_8x32.md
REGISTER_FILE_8X32 -- requirements
Module: register_file_8x32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of each register and port in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  the reset, synchronous and active-low.
REQ-004 The block SHALL have port we  input  1  the write request for the current cycle.
REQ-005 The block SHALL have port wsel  input  8  the one-hot write-register select, driven by the upstream 3-to-8 decoder.
REQ-006 The block SHALL have port wdata  input  WIDTH  the write data.
REQ-007 The block SHALL have port ra  input  3  the read port A register index.
REQ-008 The block SHALL have port rb  input  3  the read port B register index.
REQ-009 The block SHALL have port qa  output  WIDTH  the registered read data for port A.
REQ-010 The block SHALL have port qb  output  WIDTH  the registered read data for port B.
REQ-011 The block SHALL have port wack  output  1  a one-cycle pulse confirming that a write was committed.
REQ-012 The block SHALL have port sel_err  output  1  a sticky flag recording an illegal wsel value.

Function
REQ-013 The block SHALL hold 8 registers, r0 to r7, each WIDTH bits wide.
REQ-014 r0 SHALL be hardwired to zero: writes to it are discarded and reads of it return 0.
REQ-015 A write SHALL be legal only when we=1 and wsel has exactly one bit set.
REQ-016 On a legal write, register index k (where wsel[k]=1) SHALL be loaded with wdata at the clock edge.
REQ-017 wack SHALL be 1 in the cycle after a legal write and 0 otherwise; a legal write to r0 still pulses wack.
REQ-018 When we=1 and wsel is 8'h00 or has two or more bits set, no register SHALL change, wack SHALL stay 0, and sel_err SHALL be set to 1 at the next edge.
REQ-019 Once set, sel_err SHALL remain 1 until reset.
REQ-020 When we=0, wsel SHALL be ignored entirely and SHALL NOT affect sel_err.
REQ-021 Reads SHALL have a latency of one cycle: at each edge qa receives the contents of r[ra] and qb receives the contents of r[rb].
REQ-022 When ra equals rb, qa and qb SHALL carry identical values.
REQ-023 A read of a register that is being written in the same cycle SHALL follow REQ-032 / REQ-033.
REQ-024 The block SHALL contain no other state machine; the only state is the register array, qa, qb, wack and sel_err.

Reset
REQ-025 When rst_n=0 at a rising edge of clk, r1 to r7 SHALL be cleared to 0.
REQ-026 When rst_n=0 at a rising edge of clk, qa, qb and wack SHALL be cleared to 0.
REQ-027 When rst_n=0 at a rising edge of clk, sel_err SHALL be cleared to 0.
REQ-028 During reset, reset SHALL take priority over any write request in the same cycle, and that write SHALL be lost.
REQ-029 Reset SHALL NOT be asynchronous: no output may change between clock edges because of rst_n.
REQ-030 In the first cycle after rst_n rises, the block SHALL accept writes and reads normally.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL select the behaviour when a read and a write hit the same register in the same cycle.
REQ-032 With REGFILE_BYPASS_EN defined, when a legal write targets register k≠0 and ra=k (or rb=k), qa (or qb) SHALL capture wdata at that edge.
REQ-033 Without REGFILE_BYPASS_EN, qa (or qb) SHALL capture the pre-write contents, and the new value SHALL be visible one read later.
REQ-034 In both configurations, a read of r0 SHALL return 0 regardless of any bypass.

Verification
REQ-035 The bench SHALL cover reset: hold rst_n=0 with we=1, wsel=8'h04, wdata=32'hDEADBEEF -> after release, reading r2 returns 0, and wack=0, sel_err=0.
REQ-036 The bench SHALL cover a basic write/read: write r5=32'h12345678, then next cycle set ra=5 -> qa=32'h12345678 one cycle later, and wack pulsed for exactly one cycle after the write.
REQ-037 The bench SHALL cover r0: write wsel=8'h01, wdata=32'hFFFFFFFF, then read ra=0 -> qa=0, with wack=1 for the write.
REQ-038 The bench SHALL cover an illegal select: we=1, wsel=8'h06, wdata=32'hAAAA5555 -> r1 and r2 unchanged, wack=0, sel_err=1 and still 1 ten cycles later; we=0, wsel=8'h00 -> sel_err unaffected.
REQ-039 The bench SHALL cover same-cycle read/write: r3 holds 32'h1, then write r3=32'h2 with ra=3 in the same cycle -> qa=32'h2 with REGFILE_BYPASS_EN, qa=32'h1 without it.
REQ-040 The bench SHALL cover dual ports: r6=32'hA, r7=32'hB, ra=6, rb=7 -> qa=32'hA and qb=32'hB; then ra=rb=7 -> qa=qb=32'hB.
